// File: rtl/down_counter_asy.sv
// Ripple (asynchronous) binary down counter.
// Each stage is a toggle flop. Stage 0 is clocked by clk. Every higher stage
// is clocked by the rising edge of the stage below it. A 0->1 transition of
// the lower bit is a borrow, so the chain counts down. The count settles after
// the ripple has passed through all stages.
module down_counter_asy #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic             q_not
);

    // Stage 0: toggles on every rising clk edge and clears at once on reset.
    logic stage0_r;

    // Toggle the LSB stage on every counted clk edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage0_r <= 1'b0;
        end else begin
            stage0_r <= ~stage0_r;
        end
    end

    assign q[0] = stage0_r;

    // The inverted LSB output is held in its own flop that toggles with stage 0.
    // On reset it is set to 1, which matches q[0] being cleared to 0.
    logic q_not_r;

    // Maintain the complemented LSB tap alongside stage 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_not_r <= 1'b1;
        end else begin
            q_not_r <= ~q_not_r;
        end
    end

    assign q_not = q_not_r;

    // Higher stages: each one is clocked by the stage below it.
    for (genvar i = 1; i < WIDTH; i++) begin : g_stage
        logic bit_r;

        // Toggle on a borrow, i.e. when the lower stage rises 0->1.
        always_ff @(posedge q[i-1] or posedge rst) begin
            if (rst) begin
                bit_r <= 1'b0;
            end else begin
                bit_r <= ~bit_r;
            end
        end

        assign q[i] = bit_r;
    end

endmodule

// File: tb/tb_down_counter_asy.sv
// Directed testbench for the ripple down counter (WIDTH=3 and WIDTH=4).
`timescale 1ns/1ps
module tb_down_counter_asy;

    logic       clk;
    logic       rst;
    logic       rst4;
    logic [2:0] q3;
    logic       qn3;
    logic [3:0] q4;
    logic       qn4;

    int n_compared;
    int n_mismatched;

    down_counter_asy #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .q     (q3),
        .q_not (qn3)
    );

    down_counter_asy #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst4),
        .q     (q4),
        .q_not (qn4)
    );

    // 10 ns clock period; the first rising edge is at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #5000;
        $display("FAIL watchdog: observed timeout, expected finish before 5000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s @%0t: observed %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    int seq_full [20] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6, 5, 4, 3, 2, 1, 0, 7, 6, 5, 4};
    int seq_rest [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    int seq_w4   [16] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst  = 1'b1;
        rst4 = 1'b1;

        // Power-up reset; the edge at 5 ns must be ignored.
        #2;
        check("reset_q", int'(q3), 0);
        check("reset_qn", int'(qn3), 1);
        #5;  // 7 ns
        check("reset_edge_q", int'(q3), 0);
        check("reset_edge_qn", int'(qn3), 1);
        check("reset_w4_q", int'(q4), 0);

        // Release at 12 ns; 20 edges from 15 to 205 ns.
        #5;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            edge_sample();
            check($sformatf("count_q[%0d]", k), int'(q3), seq_full[k]);
            check($sformatf("count_qn[%0d]", k), int'(qn3), (seq_full[k] & 1) ^ 1);
        end

        // Now at 206 ns; assert reset mid-count at 212 ns.
        #6;
        rst = 1'b1;
        #1;
        check("async_rst_q", int'(q3), 0);
        check("async_rst_qn", int'(qn3), 1);
        edge_sample();  // 215 ns edge, ignored
        check("rst_hold_q", int'(q3), 0);
        check("rst_hold_qn", int'(qn3), 1);

        // Release at 224 ns; 10 edges from 225 to 315 ns.
        #8;
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            edge_sample();
            check($sformatf("restart_q[%0d]", k), int'(q3), seq_rest[k]);
            check($sformatf("restart_qn[%0d]", k), int'(qn3), (seq_rest[k] & 1) ^ 1);
        end

        // WIDTH=4 instance: still in reset; release between edges.
        #4;
        check("w4_pre_q", int'(q4), 0);
        check("w4_pre_qn", int'(qn4), 1);
        rst4 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            edge_sample();
            check($sformatf("w4_q[%0d]", k), int'(q4), seq_w4[k]);
            check($sformatf("w4_qn[%0d]", k), int'(qn4), (seq_w4[k] & 1) ^ 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
